// File: rtl/fetch_sequencer.sv
// Program-counter sequencer: one fetch address per cycle, stall hold, and branch
// redirect with a one-cycle IF/ID bubble and flush.
module fetch_sequencer #(
  parameter int unsigned          ADDR_W   = 64,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0,
  parameter int unsigned          CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              BrTaken,
  input  logic              UncondBr,
  input  logic [18:0]       CondAddr19,
  input  logic [25:0]       BrAddr26,
  input  logic [ADDR_W-1:0] br_pc,
  output logic [ADDR_W-1:0] pc_out,
  output logic              fetch_valid,
  output logic              flush_ifid,
  output logic [CNT_W-1:0]  fetch_count
);

  typedef enum logic [1:0] {StBoot, StRun, StRedirect} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] target;

  // Word offsets, sign-extended and scaled to bytes.
  always_comb begin
    if (UncondBr) begin
      offset = {{(ADDR_W-28){BrAddr26[25]}}, BrAddr26, 2'b00};
    end else begin
      offset = {{(ADDR_W-21){CondAddr19[18]}}, CondAddr19, 2'b00};
    end
    target = br_pc + offset;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    count_d = count_q;
    unique case (state_q)
      StBoot: begin
        state_d = StRun;
        valid_d = 1'b1;
      end
      StRun: begin
        if (BrTaken) begin
          state_d = StRedirect;
          pc_d    = target;
          valid_d = 1'b0;
        end else if (!stall) begin
          pc_d    = pc_q + ADDR_W'(4);
          valid_d = 1'b1;
          if (valid_q && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      StRedirect: begin
        if (BrTaken) begin
          pc_d = target;
        end else begin
          // Target is already in pc_q; a pending stall takes effect in RUN.
          state_d = StRun;
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = StBoot;
        pc_d    = RESET_PC;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign pc_out      = pc_q;
  assign fetch_valid = valid_q;
  assign flush_ifid  = (state_q == StRedirect);
  assign fetch_count = count_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controls the program counter for the pipelined core. It issues one fetch address per cycle to instruction memory and marks each address valid for the IF/ID register.
- Holds the PC when the hazard unit stalls. On a resolved branch it redirects the PC to the branch target, inserts a one-cycle bubble and pulses a flush for the IF/ID register.
- Sits between the hazard/branch-resolve logic and instructmem; it replaces the free-running PC register plus mux chain.

Parameters:
- ADDR_W, 64, PC/address width.
- RESET_PC, 64'd0, PC value loaded on reset.
- CNT_W, 32, width of the fetch counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- stall  input  1  hazard unit hold request; freezes PC and fetch_valid.
- BrTaken  input  1  branch resolved taken this cycle (from the branch-resolve stage).
- UncondBr  input  1  selects BrAddr26 (1) or CondAddr19 (0) as the offset source.
- CondAddr19  input  19  conditional branch word offset, signed.
- BrAddr26  input  26  unconditional branch word offset, signed.
- br_pc  input  ADDR_W  PC of the resolving branch instruction.
- pc_out  output  ADDR_W  current fetch address, registered.
- fetch_valid  output  1  pc_out holds a real fetch to be captured into IF/ID.
- flush_ifid  output  1  kill the wrong-path instruction now in IF/ID.
- fetch_count  output  CNT_W  number of accepted fetches, saturating.

Behaviour:
- Reset (reset==0, asynchronous):
  - pc_out=RESET_PC, fetch_valid=0, flush_ifid=0, fetch_count=0, state=BOOT.
  - Reset is honoured mid-operation in any state; all pending redirects are discarded.
- States: BOOT, RUN, REDIRECT; transitions are evaluated on each rising edge.
- BOOT:
  - Lasts exactly one cycle after reset deasserts; fetch_valid=0 and pc_out=RESET_PC.
  - Always goes to RUN, where the first valid fetch is RESET_PC.
  - BrTaken and stall are ignored in BOOT.
- RUN, evaluated in priority order:
  1. BrTaken=1:
     - target = br_pc + offset, where offset = UncondBr ? sext(BrAddr26)<<2 : sext(CondAddr19)<<2, sign-extended to ADDR_W.
     - Next cycle: pc_out=target, state=REDIRECT, fetch_valid=0, flush_ifid=1.
  2. Else stall=1: pc_out, fetch_valid and fetch_count hold; state stays RUN.
  3. Else: pc_out <= pc_out + 4, fetch_valid=1.
- REDIRECT:
  - Lasts one cycle. flush_ifid=1 and fetch_valid=0 (the bubble); pc_out=target.
  - Next state is RUN with pc_out unchanged, so the target is fetched valid in the first RUN cycle.
  - If stall=1 during REDIRECT, the state moves to RUN anyway; the stall then applies in RUN.
  - If BrTaken=1 during REDIRECT, the new target is loaded and the state remains REDIRECT for another cycle (newest branch wins).
- flush_ifid: asserted only during REDIRECT cycles; never in BOOT or RUN.
- fetch_count: increments on every rising edge in RUN with fetch_valid=1, stall=0 and BrTaken=0. It saturates at all ones and never wraps.
- Arithmetic:
  - Both PC+4 and target addition are modulo 2^ADDR_W. Wrap-around is silent: pc_out=64'hFFFF_FFFF_FFFF_FFFC goes to 0.
  - Negative offsets are supported via sign extension.
- Output timing: all outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.
- pc_out[1:0] is always 2'b00 provided RESET_PC and br_pc are word-aligned.

Test Plan:
- Reset/boot: hold reset=0 for 3 cycles, then release.
  - Required: pc_out=0, fetch_valid=0 for one cycle; next cycle pc_out=0, fetch_valid=1; then 4, 8, 12; fetch_count=3 after three RUN cycles.
- Stall: in RUN at pc_out=16, assert stall for 2 cycles.
  - Required: pc_out stays 16 and fetch_count is frozen; after release pc_out goes 20, 24.
- Conditional branch backward: BrTaken=1, UncondBr=0, CondAddr19=19'h7FFFE (-2), br_pc=40.
  - Required: next cycle pc_out=32, fetch_valid=0, flush_ifid=1; following cycle pc_out=32, fetch_valid=1, flush_ifid=0; then 36.
- Unconditional branch plus simultaneous stall: BrTaken=1, stall=1, UncondBr=1, BrAddr26=26'd5, br_pc=100.
  - Required: branch wins; pc_out=120 in REDIRECT; then RUN at 120.
- Back-to-back branches: BrTaken in RUN to 200, then BrTaken again during REDIRECT to 300.
  - Required: two consecutive flush_ifid cycles; first valid fetch is 300.
- Wrap plus async reset:
  - Start from pc_out=64'hFFFF_FFFF_FFFF_FFFC in RUN. Required: next pc_out=0.
  - Then assert reset low mid-cycle during REDIRECT. Required: outputs go to reset values immediately, without waiting for a clock edge.
